// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, unsigned or signed per operation.
// One multiplier bit per cycle; valid/ready on both sides, outputs are decodes of registered state.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   res,
  output logic                 busy
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               neg_q, neg_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      res_q, res_d;

  logic               a_neg_c, b_neg_c;
  logic [WIDTH-1:0]   a_mag_c, b_mag_c;
  logic [PW-1:0]      addend_c, acc_sum_c;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    a_neg_c = is_signed & op_a[WIDTH-1];
    b_neg_c = is_signed & op_b[WIDTH-1];
    a_mag_c = a_neg_c ? (~op_a) + WIDTH'(1) : op_a;
    b_mag_c = b_neg_c ? (~op_b) + WIDTH'(1) : op_b;
  end

  // One partial product per BUSY cycle.
  always_comb begin
    addend_c  = mag_b_q[cnt_q] ? (PW'(mag_a_q) << cnt_q) : '0;
    acc_sum_c = acc_q + addend_c;
  end

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mag_a_d = a_mag_c;
          mag_b_d = b_mag_c;
          neg_d   = a_neg_c ^ b_neg_c;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d = acc_sum_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = neg_q ? (~acc_sum_c) + PW'(1) : acc_sum_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_BUSY);
  assign res       = res_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH 4, 8 and 16: latency, handshakes, signed/unsigned products.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        iv8, ir8, ov8, or8, s8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        iv4, ir4, ov4, or4, s4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  r4;
  logic        iv16, ir16, ov16, or16, s16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] r16;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op_a(a8), .op_b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .res(r8), .busy(busy8));
  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op_a(a4), .op_b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .res(r4), .busy(busy4));
  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op_a(a16), .op_b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .res(r16), .busy(busy16));

  // Reference: sign- or zero-extend, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input int w, input logic s);
    longint one, ea, eb, p;
    logic [63:0] m;
    one = 1;
    ea = longint'(a) & ((one << w) - 1);
    eb = longint'(b) & ((one << w) - 1);
    if (s && a[w-1]) ea = ea - (one << w);
    if (s && b[w-1]) eb = eb - (one << w);
    p = ea * eb;
    m = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & m;
  endfunction

  // Full operation on the W=8 instance; called while idle, returns just after the handshake edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input string nm);
    int lat;
    iv8 = 1'b1; a8 = a; b8 = b; s8 = s; or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = ~a; b8 = b + 8'd1; s8 = ~s;
    n_tests++;
    if (busy8 !== 1'b1 || ir8 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: busy=%b in_ready=%b required busy=1 in_ready=0", nm, busy8, ir8);
    end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (ov8 !== 1'b1 && lat < 40);
    n_tests++;
    if (lat != 8 || ir8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (in_ready=%b busy=%b) required 8 (0,0)", nm, lat, ir8, busy8);
    end
    n_tests++;
    if (r8 !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %h required %h", nm, r8, exp);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || r8 !== exp) begin
      n_fail++;
      $display("FAIL %s handshake: in_ready=%b out_valid=%b res=%h required 1,0,%h", nm, ir8, ov8, r8, exp);
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [7:0] exp);
    int lat;
    iv4 = 1'b1; a4 = a; b4 = b; s4 = s; or4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = ~a; s4 = ~s;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (ov4 !== 1'b1 && lat < 40);
    n_tests++;
    if (lat != 4 || r4 !== exp) begin
      n_fail++;
      $display("FAIL w4 %h*%h s=%b: lat=%0d res=%h required lat=4 res=%h", a, b, s, lat, r4, exp);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL w4 handshake: in_ready=%b out_valid=%b required 1,0", ir4, ov4);
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [31:0] exp);
    int lat;
    iv16 = 1'b1; a16 = a; b16 = b; s16 = s; or16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; b16 = ~b; s16 = ~s;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (ov16 !== 1'b1 && lat < 60);
    n_tests++;
    if (lat != 16 || r16 !== exp) begin
      n_fail++;
      $display("FAIL w16 %h*%h s=%b: lat=%0d res=%h required lat=16 res=%h", a, b, s, lat, r16, exp);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0) begin
      n_fail++;
      $display("FAIL w16 handshake: in_ready=%b out_valid=%b required 1,0", ir16, ov16);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || r8 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset8: in_ready=%b out_valid=%b busy=%b res=%h required 1,0,0,0000", ir8, ov8, busy8, r8);
    end
    n_tests++;
    if (ir4 !== 1'b1 || r4 !== 8'h0 || ir16 !== 1'b1 || r16 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset4_16: in_ready=%b/%b res=%h/%h required 1/1 00/00000000", ir4, ir16, r4, r16);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    op8(8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255");
    op8(8'h80, 8'h80, 1'b0, 16'h4000, "u80x80");
    op8(8'hFF, 8'h01, 1'b0, 16'h00FF, "uFFx01");
    op8(8'h00, 8'hFF, 1'b0, 16'h0000, "u0xFF");
  endtask

  task automatic test_signed();
    op8(8'h80, 8'h80, 1'b1, 16'h4000, "s-128x-128");
    op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s-1x1");
    op8(8'h7F, 8'h80, 1'b1, 16'hC080, "s127x-128");
    op8(8'hFD, 8'h07, 1'b1, 16'hFFEB, "s-3x7");
  endtask

  task automatic test_backpressure();
    int lat;
    iv8 = 1'b1; a8 = 8'd13; b8 = 8'd11; s8 = 1'b0; or8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (ov8 !== 1'b1 && lat < 40);
    n_tests++;
    if (lat != 8) begin
      n_fail++;
      $display("FAIL bp latency: got %0d required 8", lat);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin iv8 = 1'b1; a8 = 8'd9; b8 = 8'd9; end
      if (i == 7) iv8 = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (ov8 !== 1'b1 || r8 !== 16'd143 || ir8 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp stall %0d: out_valid=%b res=%0d in_ready=%b required 1,143,0", i, ov8, r8, ir8);
      end
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || r8 !== 16'd143) begin
      n_fail++;
      $display("FAIL bp release: in_ready=%b out_valid=%b res=%0d required 1,0,143", ir8, ov8, r8);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ir8 !== 1'b1 || busy8 !== 1'b0 || ov8 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp idle: in_ready=%b busy=%b out_valid=%b required 1,0,0", ir8, busy8, ov8);
    end
  endtask

  task automatic test_reset_midop();
    iv8 = 1'b1; a8 = 8'd200; b8 = 8'd3; s8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || r8 !== 16'h0) begin
      n_fail++;
      $display("FAIL midop reset: in_ready=%b out_valid=%b busy=%b res=%h required 1,0,0,0000", ir8, ov8, busy8, r8);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
        n_fail++;
        $display("FAIL midop discard %0d: out_valid=%b in_ready=%b required 0,1", i, ov8, ir8);
      end
    end
    op8(8'd5, 8'd6, 1'b0, 16'd30, "post_reset5x6");
  endtask

  task automatic test_sweep8();
    logic [7:0] pat [16];
    pat = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h10, 8'h40, 8'h55,
            8'h7E, 8'h7F, 8'h80, 8'h81, 8'hAA, 8'hF0, 8'hFE, 8'hFF};
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          op8(pat[i], pat[j], 1'(s), 16'(ref_mul(32'(pat[i]), 32'(pat[j]), 8, 1'(s))), "sweep8");
  endtask

  task automatic test_w4();
    op4(4'h8, 4'h8, 1'b1, 8'h40);
    op4(4'hF, 4'hF, 1'b0, 8'hE1);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op4(4'(a), 4'(b), 1'(s), 8'(ref_mul(32'(a), 32'(b), 4, 1'(s))));
  endtask

  task automatic test_w16();
    logic [15:0] a, b;
    logic s;
    op16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    op16(16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 250; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      op16(a, b, s, 32'(ref_mul(32'(a), 32'(b), 16, s)));
    end
  endtask

  initial begin
    iv8 = 1'b0; or8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
    iv4 = 1'b0; or4 = 1'b0; s4 = 1'b0; a4 = '0; b4 = '0;
    iv16 = 1'b0; or16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_midop();
    test_sweep8();
    test_w4();
    test_w16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
